// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that lets two requesters (0 = core,
// 1 = loader) share one memory port. A grant is held until mem_done, then
// a one-cycle RELEASE gap precedes the next arbitration.
// Optional build macro MEM_ARB_TIMEOUT_EN adds a grant watchdog that
// completes a stuck access with an error after TIMEOUT_CYCLES grant cycles.
module mem_arbiter #(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_start,
    input  logic              m0_operation,
    input  logic [1:0]        m0_size,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_done,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_start,
    input  logic              m1_operation,
    input  logic [1:0]        m1_size,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_done,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_start,
    output logic              mem_operation,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, RELEASE} state_t;

    state_t state_reg, state_next;
    logic   last_grant_reg, last_grant_next;   // requester served most recently
    logic   granted;
    logic   timeout_hit;                       // watchdog expiry, mem_done absent

    assign granted = (state_reg == GRANT0) || (state_reg == GRANT1);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [8:0] TIMEOUT_LIMIT = 9'(TIMEOUT_CYCLES);

    logic [7:0] wdog_reg, wdog_next;

    // Count grant cycles without completion; held at zero outside a grant so it starts clean on entry
    always_comb begin
        wdog_next = 8'd0;
        if (granted && !mem_done) begin
            wdog_next = wdog_reg + 8'd1;
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_reg <= 8'd0;
        end else begin
            wdog_reg <= wdog_next;
        end
    end

    // Counter value k-1 in the k-th grant cycle, so expiry lands on cycle TIMEOUT_CYCLES;
    // a coincident mem_done takes precedence
    assign timeout_hit = granted && !mem_done &&
                         (({1'b0, wdog_reg} + 9'd1) >= TIMEOUT_LIMIT);
`else
    assign timeout_hit = 1'b0;
`endif

    // State and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;   // requester 0 wins the first contention
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
        end
    end

    // Next-state logic: arbitrate in IDLE, hold grant until completion, one RELEASE gap
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            IDLE: begin
                if (m0_start && (!m1_start || last_grant_reg)) begin
                    state_next      = GRANT0;
                    last_grant_next = 1'b0;
                end else if (m1_start) begin
                    state_next      = GRANT1;
                    last_grant_next = 1'b1;
                end
            end
            GRANT0, GRANT1: begin
                if (mem_done || timeout_hit) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output steering; everything is forced low while reset is asserted
    always_comb begin
        mem_start     = 1'b0;
        mem_operation = 1'b0;
        mem_size      = 2'b00;
        mem_addr      = '0;
        mem_wdata     = '0;
        m0_done       = 1'b0;
        m0_err        = 1'b0;
        m0_rdata      = '0;
        m1_done       = 1'b0;
        m1_err        = 1'b0;
        m1_rdata      = '0;
        if (!reset) begin
            case (state_reg)
                GRANT0: begin
                    mem_start     = !timeout_hit;
                    mem_operation = m0_operation;
                    mem_size      = m0_size;
                    mem_addr      = m0_addr;
                    mem_wdata     = m0_wdata;
                    m0_done       = mem_done || timeout_hit;
                    m0_err        = timeout_hit;
                    m0_rdata      = mem_done ? mem_rdata : '0;
                end
                GRANT1: begin
                    mem_start     = !timeout_hit;
                    mem_operation = m1_operation;
                    mem_size      = m1_size;
                    mem_addr      = m1_addr;
                    mem_wdata     = m1_wdata;
                    m1_done       = mem_done || timeout_hit;
                    m1_err        = timeout_hit;
                    m1_rdata      = mem_done ? mem_rdata : '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven check of mem_arbiter (one row per clock cycle)
// followed by hand-written sequences for the long-grant / watchdog cases.
module tb_mem_arbiter;

    typedef struct packed {
        logic        s;
        logic        op;
        logic [1:0]  sz;
        logic [63:0] a;
        logic [63:0] wd;
    } req_t;

    typedef struct {
        logic        rst;
        req_t        q0;
        req_t        q1;
        logic        md;
        logic [63:0] mrd;
        int          eg;    // expected grant: 0 none, 1 requester 0, 2 requester 1
        logic        ed;    // expected done for the granted requester
        logic        ee;    // expected err for the granted requester
        logic [63:0] erd;   // expected rdata for the granted requester
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_start, m0_operation, m1_start, m1_operation;
    logic [1:0]  m0_size, m1_size;
    logic [63:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_done, m0_err, m1_done, m1_err;
    logic [63:0] m0_rdata, m1_rdata;
    logic        mem_start, mem_operation, mem_done;
    logic [1:0]  mem_size;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .m0_start(m0_start), .m0_operation(m0_operation), .m0_size(m0_size),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_start(m1_start), .m1_operation(m1_operation), .m1_size(m1_size),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .mem_start(mem_start), .mem_operation(mem_operation), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata)
    );

    function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endfunction

    function automatic void add(logic rst, req_t q0, req_t q1, logic md, logic [63:0] mrd,
                                int eg, logic ed, logic ee, logic [63:0] erd);
        vec_t v;
        v.rst = rst; v.q0 = q0; v.q1 = q1; v.md = md; v.mrd = mrd;
        v.eg = eg; v.ed = ed; v.ee = ee; v.erd = erd;
        vecs.push_back(v);
    endfunction

    task automatic drive(logic rst, req_t q0, req_t q1, logic md, logic [63:0] mrd);
        reset        = rst;
        m0_start     = q0.s;  m0_operation = q0.op; m0_size = q0.sz;
        m0_addr      = q0.a;  m0_wdata     = q0.wd;
        m1_start     = q1.s;  m1_operation = q1.op; m1_size = q1.sz;
        m1_addr      = q1.a;  m1_wdata     = q1.wd;
        mem_done     = md;
        mem_rdata    = mrd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    req_t N, Q0, Q0_OFF, Q0B, Q1B, Q1W;
    localparam logic [63:0] RD = 64'hDEADBEEF;

    initial begin
        N      = '0;
        Q0     = '{s: 1'b1, op: 1'b0, sz: 2'b10, a: 64'h100, wd: 64'h0};
        Q0_OFF = '{s: 1'b0, op: 1'b0, sz: 2'b10, a: 64'h100, wd: 64'h0};
        Q0B    = '{s: 1'b1, op: 1'b0, sz: 2'b01, a: 64'h200, wd: 64'h1111};
        Q1B    = '{s: 1'b1, op: 1'b0, sz: 2'b00, a: 64'h300, wd: 64'h2222};
        Q1W    = '{s: 1'b1, op: 1'b1, sz: 2'b11, a: 64'h400, wd: 64'h0123456789ABCDEF};

        //  rst q0      q1   md    mrd         eg ed ee erd
        // reset: outputs low even with requests and mem_done present
        add(1, N,      N,   0, 64'h0,       0, 0, 0, 64'h0);   // 0
        add(1, Q0,     N,   1, RD,          0, 0, 0, 64'h0);   // 1
        // single read by requester 0, mem_done on the third grant cycle
        add(0, Q0,     N,   0, 64'h0,       0, 0, 0, 64'h0);   // 2  cycle n
        add(0, Q0,     N,   0, 64'h0,       1, 0, 0, 64'h0);   // 3  n+1
        add(0, Q0,     N,   0, 64'h55,      1, 0, 0, 64'h0);   // 4  rdata masked
        add(0, Q0,     N,   1, RD,          1, 1, 0, RD);      // 5  done
        add(0, N,      N,   0, 64'h0,       0, 0, 0, 64'h0);   // 6  RELEASE
        add(0, N,      N,   0, 64'h0,       0, 0, 0, 64'h0);   // 7  IDLE
        // contention after reset: 0, 1, 0
        add(1, N,      N,   0, 64'h0,       0, 0, 0, 64'h0);   // 8
        add(0, Q0B,    Q1B, 0, 64'h0,       0, 0, 0, 64'h0);   // 9
        add(0, Q0B,    Q1B, 1, 64'hA0,      1, 1, 0, 64'hA0);  // 10
        add(0, Q0B,    Q1B, 0, 64'h0,       0, 0, 0, 64'h0);   // 11 RELEASE
        add(0, Q0B,    Q1B, 0, 64'h0,       0, 0, 0, 64'h0);   // 12 IDLE
        add(0, Q0B,    Q1B, 1, 64'hA1,      2, 1, 0, 64'hA1);  // 13
        add(0, Q0B,    Q1B, 0, 64'h0,       0, 0, 0, 64'h0);   // 14
        add(0, Q0B,    Q1B, 0, 64'h0,       0, 0, 0, 64'h0);   // 15
        add(0, Q0B,    Q1B, 1, 64'hA2,      1, 1, 0, 64'hA2);  // 16
        add(0, N,      N,   0, 64'h0,       0, 0, 0, 64'h0);   // 17
        add(0, N,      N,   1, 64'hBAD,     0, 0, 0, 64'h0);   // 18 mem_done in IDLE ignored
        add(0, N,      N,   0, 64'h0,       0, 0, 0, 64'h0);   // 19
        // requester 1 doubleword write; mem_done in RELEASE ignored
        add(0, N,      Q1W, 0, 64'h0,       0, 0, 0, 64'h0);   // 20
        add(0, N,      Q1W, 0, 64'h0,       2, 0, 0, 64'h0);   // 21
        add(0, N,      Q1W, 1, 64'h99,      2, 1, 0, 64'h99);  // 22
        add(0, N,      Q1W, 1, 64'h98,      0, 0, 0, 64'h0);   // 23 RELEASE
        add(0, N,      N,   0, 64'h0,       0, 0, 0, 64'h0);   // 24
        // reset in the middle of a grant, late mem_done ignored
        add(0, Q0,     N,   0, 64'h0,       0, 0, 0, 64'h0);   // 25
        add(0, Q0,     N,   0, 64'h0,       1, 0, 0, 64'h0);   // 26
        add(1, Q0,     N,   0, 64'h0,       0, 0, 0, 64'h0);   // 27
        add(0, N,      N,   1, RD,          0, 0, 0, 64'h0);   // 28
        add(0, N,      N,   0, 64'h0,       0, 0, 0, 64'h0);   // 29
        // requester drops start while granted: grant held, done still pulses
        add(0, Q0,     N,   0, 64'h0,       0, 0, 0, 64'h0);   // 30
        add(0, Q0_OFF, N,   0, 64'h0,       1, 0, 0, 64'h0);   // 31
        add(0, Q0_OFF, N,   1, 64'h5A,      1, 1, 0, 64'h5A);  // 32
        add(0, N,      N,   0, 64'h0,       0, 0, 0, 64'h0);   // 33
        add(0, N,      N,   0, 64'h0,       0, 0, 0, 64'h0);   // 34

        foreach (vecs[i]) begin
            vec_t v;
            req_t g;
            v = vecs[i];
            g = (v.eg == 1) ? v.q0 : (v.eg == 2) ? v.q1 : N;
            drive(v.rst, v.q0, v.q1, v.md, v.mrd);
            @(negedge clk);
            $display("vec %0d: mem_start=%0b addr=0x%0h m0_done=%0b m1_done=%0b",
                     i, mem_start, mem_addr, m0_done, m1_done);
            chk($sformatf("v%0d mem_start", i),     64'(mem_start),     64'(v.eg != 0));
            chk($sformatf("v%0d mem_operation", i), 64'(mem_operation), 64'(g.op));
            chk($sformatf("v%0d mem_size", i),      64'(mem_size),      64'(g.sz));
            chk($sformatf("v%0d mem_addr", i),      mem_addr,           g.a);
            chk($sformatf("v%0d mem_wdata", i),     mem_wdata,          g.wd);
            chk($sformatf("v%0d m0_done", i),  64'(m0_done), 64'((v.eg == 1) && v.ed));
            chk($sformatf("v%0d m0_err", i),   64'(m0_err),  64'((v.eg == 1) && v.ee));
            chk($sformatf("v%0d m0_rdata", i), m0_rdata,     (v.eg == 1) ? v.erd : 64'h0);
            chk($sformatf("v%0d m1_done", i),  64'(m1_done), 64'((v.eg == 2) && v.ed));
            chk($sformatf("v%0d m1_err", i),   64'(m1_err),  64'((v.eg == 2) && v.ee));
            chk($sformatf("v%0d m1_rdata", i), m1_rdata,     (v.eg == 2) ? v.erd : 64'h0);
            next_cycle();
        end

`ifdef MEM_ARB_TIMEOUT_EN
        // watchdog: mem_done never comes, error completion on the 4th grant cycle
        drive(0, Q0, N, 0, 64'h0);
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            @(negedge clk);
            $display("timeout cycle %0d: mem_start=%0b m0_done=%0b m0_err=%0b",
                     k, mem_start, m0_done, m0_err);
            chk($sformatf("to%0d mem_start", k), 64'(mem_start), 64'(k < 4));
            chk($sformatf("to%0d m0_done", k),   64'(m0_done),   64'(k == 4));
            chk($sformatf("to%0d m0_err", k),    64'(m0_err),    64'(k == 4));
        end
        next_cycle();
        drive(0, N, N, 0, 64'h0);
        @(negedge clk);
        $display("timeout release: mem_start=%0b m0_done=%0b", mem_start, m0_done);
        chk("to release mem_start", 64'(mem_start), 64'h0);
        chk("to release m0_done",   64'(m0_done),   64'h0);
        next_cycle();
        @(negedge clk);
        chk("to idle mem_start", 64'(mem_start), 64'h0);
        // mem_done coinciding with expiry wins
        drive(0, Q0, N, 0, 64'h0);
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            drive(0, Q0, N, (k == 4), (k == 4) ? 64'hC0DE : 64'h0);
            @(negedge clk);
            $display("coincide cycle %0d: m0_done=%0b m0_err=%0b", k, m0_done, m0_err);
            chk($sformatf("co%0d m0_done", k), 64'(m0_done), 64'(k == 4));
            chk($sformatf("co%0d m0_err", k),  64'(m0_err),  64'h0);
        end
        chk("co m0_rdata", m0_rdata, 64'hC0DE);
        next_cycle();
        drive(0, N, N, 0, 64'h0);
`else
        // no watchdog: a grant waits for mem_done indefinitely
        begin
            int held;
            held = 0;
            drive(0, N, Q1B, 0, 64'h0);
            for (int k = 0; k < 1000; k++) begin
                next_cycle();
                @(negedge clk);
                if (mem_start && (mem_addr == 64'h300) && !m1_done && !m1_err && !m0_err)
                    held++;
            end
            $display("hold: %0d of 1000 cycles granted without completion", held);
            chk("hold cycles", 64'(held), 64'd1000);
            next_cycle();
            drive(0, N, Q1B, 1, 64'h1234);
            @(negedge clk);
            $display("hold end: m1_done=%0b m1_err=%0b m1_rdata=0x%0h", m1_done, m1_err, m1_rdata);
            chk("hold m1_done",  64'(m1_done), 64'h1);
            chk("hold m1_err",   64'(m1_err),  64'h0);
            chk("hold m1_rdata", m1_rdata,     64'h1234);
            next_cycle();
            drive(0, N, N, 0, 64'h0);
            @(negedge clk);
            chk("hold release mem_start", 64'(mem_start), 64'h0);
        end
`endif

        next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64: address width.
REQ-002 SHALL have parameter DATA_W, default 64: data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: watchdog limit in cycles, 8-bit range.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on posedge clk.
REQ-005 SHALL have port reset  in  1  reset; synchronous, active-high.
REQ-006 SHALL have ports m0_start / m1_start  in  1  requester 0 (core) / requester 1 (loader) request, level, held until done.
REQ-007 SHALL have ports m0_operation / m1_operation  in  1  0 = read, 1 = write.
REQ-008 SHALL have ports m0_size / m1_size  in  2  access size: 00 b, 01 h, 10 w, 11 d.
REQ-009 SHALL have ports m0_addr / m1_addr  in  ADDR_W, and m0_wdata / m1_wdata  in  DATA_W: request address and write data.
REQ-010 SHALL have ports m0_done / m1_done  out  1, m0_err / m1_err  out  1, m0_rdata / m1_rdata  out  DATA_W: completion pulse, error flag, read data.
REQ-011 SHALL have ports mem_start  out  1, mem_operation  out  1, mem_size  out  2, mem_addr  out  ADDR_W, mem_wdata  out  DATA_W toward the shared memory.
REQ-012 SHALL have ports mem_done  in  1 (one-cycle completion pulse) and mem_rdata  in  DATA_W.

Function
REQ-013 SHALL implement states IDLE, GRANT0, GRANT1, RELEASE.
REQ-014 IDLE: only m0_start -> GRANT0; only m1_start -> GRANT1; both -> requester not recorded in last_grant; neither -> IDLE.
REQ-015 last_grant SHALL update to the served requester on entry to GRANT0/GRANT1.
REQ-016 GRANTx: mem_start = 1 and mem_operation/size/addr/wdata SHALL combinationally follow requester x's inputs; with no grant, all mem_* outputs SHALL be 0.
REQ-017 Arbitration latency SHALL be one cycle: request sampled in IDLE at cycle n, mem_start asserted at cycle n+1.
REQ-018 In GRANTx, mem_done = 1 SHALL assert mx_done for that same cycle, with mx_rdata = mem_rdata, mx_err = 0, and next state RELEASE.
REQ-019 mx_rdata SHALL be 0 when mx_done = 0; the non-granted requester's done/err/rdata SHALL be 0.
REQ-020 RELEASE SHALL last exactly one cycle, drive mem_start = 0, then go to IDLE, so a requester dropping start after done is not regranted.
REQ-021 If a requester drops start while granted, the grant SHALL be held until mem_done (no abort), and done SHALL still pulse.
REQ-022 mem_done arriving in IDLE or RELEASE SHALL be ignored: no done pulse, no state change.
REQ-023 A requester still asserting start in IDLE after RELEASE SHALL be regranted only per REQ-014 round-robin.

Reset
REQ-024 reset SHALL force state IDLE and last_grant = 1 (requester 0 wins first contention), and SHALL clear the watchdog counter.
REQ-025 While reset = 1 and in the cycle after, all outputs SHALL be 0.
REQ-026 reset asserted mid-grant SHALL abort the transaction without a done pulse; a later mem_done SHALL be ignored per REQ-022.

Configuration
REQ-027 Macro MEM_ARB_TIMEOUT_EN defined: an 8-bit counter SHALL clear on grant entry and increment each GRANTx cycle without mem_done.
REQ-028 On reaching TIMEOUT_CYCLES with MEM_ARB_TIMEOUT_EN defined, the block SHALL pulse mx_done = 1 and mx_err = 1 for one cycle, drop mem_start, and go to RELEASE.
REQ-029 With MEM_ARB_TIMEOUT_EN defined and mem_done coinciding with timeout, mem_done SHALL win (err = 0).
REQ-030 Without MEM_ARB_TIMEOUT_EN: no counter, m0_err = m1_err = 0 constant, and the grant waits indefinitely.

Verification
REQ-031 Bench SHALL cover: m0_start=1, addr=0x100, read; mem_done at 3rd grant cycle with rdata=0xDEADBEEF -> mem_start cycles n+1..n+3, m0_done pulse with m0_rdata=0xDEADBEEF, m1 outputs 0.
REQ-032 Bench SHALL cover: m0_start and m1_start both high after reset -> GRANT0 first; next contention -> GRANT1; alternation continues.
REQ-033 Bench SHALL cover: m1 write, size=11, wdata=0x0123456789ABCDEF -> mem_operation=1, mem_size=11, mem_wdata matches; RELEASE cycle shows mem_start=0.
REQ-034 Bench SHALL cover: reset pulsed during GRANT0 before mem_done -> IDLE next cycle, no m0_done; a mem_done one cycle later is ignored.
REQ-035 Bench SHALL cover, with MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4: mem_done never asserted -> m0_done=1 and m0_err=1 on the 4th grant cycle, then RELEASE, then IDLE; without the macro the grant holds for 1000 cycles.
